data_mem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the MIPS core's load/store path (CPU) and a DMA/debug loader (DMA).
- Sits between the core/DMA and the data_mem instance in the cpu top.
- Fixed CPU priority with a DMA anti-starvation counter.
- One transaction in flight at a time; configurable memory read latency.

---
 rtl/data_mem_arbiter_if.sv | 44 ++++
 rtl/data_mem_arbiter.sv | 112 +++++++++++
 tb/tb_data_mem_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the CPU / DMA requesters, the data-memory arbiter and the data memory.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requester and memory side of the bundle
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Arbiter side of the bundle
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares one data-memory port between the CPU load/store path and a DMA loader.
// CPU has fixed priority; DMA is forced through after MAX_WAIT consecutive losses.
module data_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input logic             clk,
  input logic             rst,
  data_mem_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [LW-1:0] LAT_WAIT = LW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic          grant_dma;
  logic          lat_we;
  logic [LW-1:0] lat_cnt;
  logic [WW-1:0] wait_cnt;
  logic          dma_wins;

  assign dma_wins = bus.dma_req && (!bus.cpu_req || (wait_cnt >= WAIT_MAX));

  // The memory address/data registers double as the latched request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant_dma     <= 1'b0;
      lat_we        <= 1'b0;
      lat_cnt       <= '0;
      wait_cnt      <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.dma_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_rdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            grant_dma <= dma_wins;
            state     <= ISSUE;
            if (dma_wins) begin
              lat_we        <= bus.dma_we;
              bus.mem_we    <= bus.dma_we;
              bus.mem_addr  <= bus.dma_addr;
              bus.mem_wdata <= bus.dma_wdata;
            end else begin
              lat_we        <= bus.cpu_we;
              bus.mem_we    <= bus.cpu_we;
              bus.mem_addr  <= bus.cpu_addr;
              bus.mem_wdata <= bus.cpu_wdata;
            end
          end
          if (!bus.dma_req || dma_wins) begin
            wait_cnt <= '0;
          end else if (wait_cnt < WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ISSUE: begin
          bus.mem_we <= 1'b0;
          if (lat_we || (MEM_LAT == 1)) begin
            if (!lat_we) begin
              if (grant_dma) bus.dma_rdata <= bus.mem_rdata;
              else           bus.cpu_rdata <= bus.mem_rdata;
            end
            bus.dma_ack <= grant_dma;
            bus.cpu_ack <= !grant_dma;
            state       <= RESP;
          end else begin
            lat_cnt <= LAT_WAIT;
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (lat_cnt == LW'(1)) begin
            if (grant_dma) bus.dma_rdata <= bus.mem_rdata;
            else           bus.cpu_rdata <= bus.mem_rdata;
            bus.dma_ack <= grant_dma;
            bus.cpu_ack <= !grant_dma;
            state       <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        RESP: begin
          bus.cpu_ack <= 1'b0;
          bus.dma_ack <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_data_mem_arbiter;
  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_WAIT(4)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1)
  );
  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_WAIT(4)) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3)
  );

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];

  // Word-indexed memories; reads are combinational on the held address.
  assign bus1.mem_rdata = mem1[bus1.mem_addr[7:0]];
  assign bus3.mem_rdata = mem3[bus3.mem_addr[7:0]];
  always @(posedge clk) if (bus1.mem_we) mem1[bus1.mem_addr[7:0]] = bus1.mem_wdata;
  always @(posedge clk) if (bus3.mem_we) mem3[bus3.mem_addr[7:0]] = bus3.mem_wdata;

  typedef struct {
    bit          dma;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1;
  exp_t e3;
  int   errors = 0;
  int   checks = 0;
  int   we_cycles1 = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Every ack is matched against the oldest predicted completion.
  always @(negedge clk) begin
    if (bus1.mem_we) we_cycles1++;
    if (bus1.cpu_ack || bus1.dma_ack) begin
      if (q1.size() == 0) begin
        checkOutput("sb1_unexpected_ack", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        checkOutput("sb1_grant", 32'({bus1.dma_ack, bus1.cpu_ack}), e1.dma ? 32'd2 : 32'd1);
        if (e1.rd) checkOutput("sb1_rdata", e1.dma ? bus1.dma_rdata : bus1.cpu_rdata, e1.data);
      end
    end
  end

  always @(negedge clk) begin
    if (bus3.cpu_ack || bus3.dma_ack) begin
      if (q3.size() == 0) begin
        checkOutput("sb3_unexpected_ack", 32'd1, 32'd0);
      end else begin
        e3 = q3.pop_front();
        checkOutput("sb3_grant", 32'({bus3.dma_ack, bus3.cpu_ack}), e3.dma ? 32'd2 : 32'd1);
        if (e3.rd) checkOutput("sb3_rdata", e3.dma ? bus3.dma_rdata : bus3.cpu_rdata, e3.data);
      end
    end
  end

  // Drives one request on bus1 and holds it until its ack (bounded).
  task automatic applyStimulus(input bit dma, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bit got = 1'b0;
    if (dma) begin
      bus1.dma_we = we; bus1.dma_addr = addr; bus1.dma_wdata = wdata; bus1.dma_req = 1'b1;
    end else begin
      bus1.cpu_we = we; bus1.cpu_addr = addr; bus1.cpu_wdata = wdata; bus1.cpu_req = 1'b1;
    end
    for (int n = 0; n < 50 && !got; n++) begin
      @(posedge clk); #1;
      got = dma ? bus1.dma_ack : bus1.cpu_ack;
    end
    checkOutput(dma ? "dma_ack_seen" : "cpu_ack_seen", 32'(got), 32'd1);
    if (dma) bus1.dma_req = 1'b0;
    else     bus1.cpu_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    rst1 = 1'b1; rst3 = 1'b1;
    bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
    bus1.dma_req = 0; bus1.dma_we = 0; bus1.dma_addr = 0; bus1.dma_wdata = 0;
    bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_addr = 0; bus3.cpu_wdata = 0;
    bus3.dma_req = 0; bus3.dma_we = 0; bus3.dma_addr = 0; bus3.dma_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'h5A00_0000 + 32'(i);
      mem3[i] = 32'h3300_0000 + 32'(i);
    end
    mem1[8'h10] = 32'hDEADBEEF;
    mem1[8'h50] = 32'hD0D0_0050;
    mem3[8'h30] = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0; rst3 = 1'b0;

    checkOutput("rst_cpu_ack", 32'(bus1.cpu_ack), 32'd0);
    checkOutput("rst_dma_ack", 32'(bus1.dma_ack), 32'd0);
    checkOutput("rst_mem_we", 32'(bus1.mem_we), 32'd0);
    checkOutput("rst_mem_addr", bus1.mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", bus1.mem_wdata, 32'd0);
    checkOutput("rst_cpu_rdata", bus1.cpu_rdata, 32'd0);
    checkOutput("rst_wait_cnt", 32'(dut1.wait_cnt), 32'd0);

    // Single CPU read, cycle by cycle
    bus1.cpu_we = 1'b0; bus1.cpu_addr = 32'h10; bus1.cpu_req = 1'b1;
    q1.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
    @(posedge clk); #1;
    checkOutput("rd1_issue_we", 32'(bus1.mem_we), 32'd0);
    checkOutput("rd1_issue_addr", bus1.mem_addr, 32'h10);
    checkOutput("rd1_issue_ack", 32'(bus1.cpu_ack), 32'd0);
    @(posedge clk); #1;
    checkOutput("rd1_resp_ack", 32'(bus1.cpu_ack), 32'd1);
    checkOutput("rd1_resp_rdata", bus1.cpu_rdata, 32'hDEADBEEF);
    checkOutput("rd1_resp_dma_ack", 32'(bus1.dma_ack), 32'd0);
    bus1.cpu_req = 1'b0;
    @(posedge clk); #1;
    checkOutput("rd1_ack_pulse", 32'(bus1.cpu_ack), 32'd0);
    checkOutput("rd1_rdata_held", bus1.cpu_rdata, 32'hDEADBEEF);

    // Simultaneous CPU write and DMA read of the same word
    we_cycles1 = 0;
    q1.push_back('{1'b0, 1'b0, 32'h0});
    q1.push_back('{1'b1, 1'b1, 32'h12345678});
    fork
      applyStimulus(1'b0, 1'b1, 32'h20, 32'h12345678);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
    join
    checkOutput("wr_we_cycles", 32'(we_cycles1), 32'd1);
    checkOutput("wr_cpu_rdata_kept", bus1.cpu_rdata, 32'hDEADBEEF);

    // Starvation: four CPU wins, then DMA is forced through
    for (int i = 0; i < 4; i++) q1.push_back('{1'b0, 1'b1, 32'h5A00_0040 + 32'(i)});
    q1.push_back('{1'b1, 1'b1, 32'hD0D0_0050});
    q1.push_back('{1'b0, 1'b1, 32'h5A00_0044});
    fork
      begin
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h40 + 32'(i), 32'h0);
      end
      begin
        applyStimulus(1'b1, 1'b0, 32'h50, 32'h0);
        checkOutput("starve_wait_clr", 32'(dut1.wait_cnt), 32'd0);
      end
    join

    // Quiet bus
    repeat (20) begin
      @(posedge clk); #1;
      checkOutput("idle_mem_we", 32'(bus1.mem_we), 32'd0);
      checkOutput("idle_acks", 32'({bus1.cpu_ack, bus1.dma_ack}), 32'd0);
      checkOutput("idle_state", 32'(dut1.state), 32'd0);
      checkOutput("idle_wait_cnt", 32'(dut1.wait_cnt), 32'd0);
    end

    // MEM_LAT=3 read: ISSUE, two WAIT cycles, RESP
    bus3.cpu_we = 1'b0; bus3.cpu_addr = 32'h30; bus3.cpu_req = 1'b1;
    q3.push_back('{1'b0, 1'b1, 32'hCAFEF00D});
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("l3_addr", bus3.mem_addr, 32'h30);
      checkOutput("l3_we", 32'(bus3.mem_we), 32'd0);
      checkOutput("l3_early_ack", 32'(bus3.cpu_ack), 32'd0);
    end
    @(posedge clk); #1;
    checkOutput("l3_ack", 32'(bus3.cpu_ack), 32'd1);
    checkOutput("l3_rdata", bus3.cpu_rdata, 32'hCAFEF00D);
    bus3.cpu_req = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a WAIT drops the read without an ack
    bus3.cpu_addr = 32'h34; bus3.cpu_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst3 = 1'b1;
    #1;
    checkOutput("arst_cpu_ack", 32'(bus3.cpu_ack), 32'd0);
    checkOutput("arst_cpu_rdata", bus3.cpu_rdata, 32'd0);
    checkOutput("arst_mem_addr", bus3.mem_addr, 32'd0);
    checkOutput("arst_mem_we", 32'(bus3.mem_we), 32'd0);
    checkOutput("arst_state", 32'(dut3.state), 32'd0);
    bus3.cpu_req = 1'b0;
    @(posedge clk); #1 rst3 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    bus3.cpu_addr = 32'h30; bus3.cpu_req = 1'b1;
    q3.push_back('{1'b0, 1'b1, 32'hCAFEF00D});
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      got = bus3.cpu_ack;
    end
    checkOutput("l3_after_rst_ack", 32'(got), 32'd1);
    bus3.cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    checkOutput("sb1_drained", 32'(q1.size()), 32'd0);
    checkOutput("sb3_drained", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
